// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive controller.
//               Optional feature macro: UART_RX_PARITY_EN (even parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

`ifdef UART_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // bit_idx encoding: start is 0, data bits 1..N, then parity (if any), then stop
    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_STOP  = 4'(DATA_BITS_DEF + 1 + PARITY_BITS);

    function automatic logic [3:0] bit_stop_idx(input int data_bits);
        return 4'(data_bits + 1 + PARITY_BITS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Delivery and status bundle of the UART receive controller.
//               master = receiver side, slave = consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic [3:0]           bit_idx;
    logic                 busy;
    logic                 framing_err;
    logic                 overrun_err;
    logic                 parity_err;

    modport master (
        output data_out, data_valid, bit_idx, busy,
               framing_err, overrun_err, parity_err,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, bit_idx, busy,
               framing_err, overrun_err, parity_err,
        output data_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the raw serial line plus a
//               tick-sampled previous value for falling-edge detection.
//               All flops reset to the idle (high) line level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic rx_in,
    input  wire logic sample_tick,
    output logic      rx_s,
    output logic      rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two-stage metastability filter on the asynchronous line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx_in;
            r_sync <= r_meta;
        end
    end

    // Line level seen at the previous sample tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b1;
        end else if (sample_tick) begin
            r_prev <= r_sync;
        end
    end

    assign rx_s    = r_sync;
    assign rx_fall = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller. Start detection with false-start
//               rejection, mid-bit sampling, LSB-first shifting, stop check,
//               valid/ready holding register with framing/overrun flags.
//               Optional feature macro: UART_RX_PARITY_EN (even parity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       rx_in,
    input  wire logic       sample_tick,
    uart_rx_ctrl_if.master  bus
);

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]     IDX_STOP  = bit_stop_idx(DATA_BITS);

    logic w_rx_s;
    logic w_rx_fall;

    rx_state_t             r_state,   w_state_n;
    logic [CW-1:0]         r_cnt,     w_cnt_n;
    logic [3:0]            r_idx,     w_idx_n;
    logic [DATA_BITS-1:0]  r_shift,   w_shift_n;
    logic                  r_par_bad, w_par_bad_n;
    logic                  w_good;
    logic                  w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                  w_par_err;
    logic                  r_par_err;
`endif

    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;

    uart_rx_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .sample_tick (sample_tick),
        .rx_s        (w_rx_s),
        .rx_fall     (w_rx_fall)
    );

    // Frame sequencer state register; advances only on sample ticks via next-state logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= BIT_START;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_idx     <= w_idx_n;
            r_shift   <= w_shift_n;
            r_par_bad <= w_par_bad_n;
        end
    end

    // Next-state, counter, shift and frame-decision logic
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_par_bad_n = r_par_bad;
        w_good      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err   = 1'b0;
`endif
        if (sample_tick) begin
            case (r_state)
                IDLE: begin
                    // Needs a genuine high-to-low transition, so a held-low break never retriggers
                    if (w_rx_fall) begin
                        w_state_n = START;
                        w_cnt_n   = '0;
                        w_idx_n   = BIT_START;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_n = '0;
                        if (!w_rx_s) begin
                            w_state_n = DATA;
                            w_idx_n   = 4'd1;
                        end else begin
                            w_state_n = IDLE;
                            w_idx_n   = BIT_START;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        w_cnt_n     = '0;
                        w_shift_n   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_par_bad_n = 1'b0;
                        if (r_idx == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                            w_state_n = PARITY;
                            w_idx_n   = r_idx + 4'd1;
`else
                            w_state_n = STOP;
                            w_idx_n   = IDX_STOP;
`endif
                        end else begin
                            w_idx_n = r_idx + 4'd1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == CNT_FULL) begin
                        w_cnt_n   = '0;
                        w_state_n = STOP;
                        w_idx_n   = IDX_STOP;
                        if (w_rx_s != ^r_shift) begin
                            w_par_err   = 1'b1;
                            w_par_bad_n = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        w_cnt_n   = '0;
                        w_state_n = IDLE;
                        w_idx_n   = BIT_START;
                        if (!w_rx_s) begin
                            w_frame_err = 1'b1;
                        end else if (!r_par_bad) begin
                            w_good = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                    w_idx_n   = BIT_START;
                end
            endcase
        end
    end

    // Holding register, handshake and one-clk error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_good) begin
                // A consumer read in the same clk frees the register for the new byte
                if (!r_valid || bus.data_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch pulse, aligned with the other error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err;
        end
    end
    assign bus.parity_err = r_par_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data_out    = r_data;
    assign bus.data_valid  = r_valid;
    assign bus.bit_idx     = r_idx;
    assign bus.busy        = (r_state != IDLE);
    assign bus.framing_err = r_frame_err;
    assign bus.overrun_err = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl with a byte scoreboard.
//               Optional feature macro: UART_RX_PARITY_EN (even parity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = DB + 2 + PAR;
    // Edge (counted from the edge before the start bit is driven) that samples the stop bit:
    // 2 synchronizer clks + 1 edge-detect clk + half bit + one full bit per data/parity/stop
    localparam int STOP_EDGE = 3 + OS / 2 + OS * (DB + 1 + PAR);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_in = 1'b1;
    logic sample_tick = 1'b1;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .sample_tick (sample_tick),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_rise_cyc = 0;
    int valid_rises = 0;
    int fe_cnt = 0;
    int oe_cnt = 0;
    int pe_cnt = 0;
    bit busy_seen = 1'b0;
    bit prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses, records valid rise time, scores transfers
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.framing_err) fe_cnt++;
            if (bus.overrun_err) oe_cnt++;
            if (bus.parity_err)  pe_cnt++;
            if (bus.busy)        busy_seen = 1'b1;
            if (bus.data_valid && !prev_valid) begin
                valid_rise_cyc = cyc;
                valid_rises++;
            end
            prev_valid = bus.data_valid;
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0)
                    check_eq("spurious_data", 32'(exp_q.size()), 32'd1);
                else
                    check_eq("data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_counts();
        fe_cnt = 0; oe_cnt = 0; pe_cnt = 0; valid_rises = 0; busy_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame at OS clks per bit. rdy_pulse raises data_ready only on the
    // stop-sample clk; abort_at >= 0 asserts reset at that clk offset and ends the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                              input bit rdy_pulse, input int abort_at, input bit probe);
        logic fb [NBITS];
        fb[0] = 1'b0;
        for (int i = 0; i < DB; i++) fb[i+1] = d[i];
        if (PAR == 1) fb[DB+1] = par_v;
        fb[NBITS-1] = stop_v;
        for (int c = 0; c < NBITS * OS; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) start_cyc = cyc;
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check_eq("async_reset_outputs",
                         {15'd0, bus.data_valid, bus.busy, bus.framing_err, bus.overrun_err,
                          bus.parity_err, bus.bit_idx, bus.data_out}, 32'd0);
                rx_in = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            rx_in = fb[c / OS];
            if (rdy_pulse) begin
                if (c == STOP_EDGE - 1) bus.data_ready = 1'b1;
                else if (c == STOP_EDGE) bus.data_ready = 1'b0;
            end
            // Offset 100 lies in data bit 6: bit_idx=1 from edge 11, +1 every 16 edges
            if (probe && c == 100) begin
                check_eq("bit_idx_mid", 32'(bus.bit_idx), 32'd6);
                check_eq("busy_mid", 32'(bus.busy), 32'd1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pats [4];
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h81; pats[3] = 8'h3C;
        bus.data_ready = 1'b1;
        reset = 1'b0;
        #1;
        idle(3);
        check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
        check_eq("rst_valid", 32'(bus.data_valid), 32'd0);
        check_eq("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_flags", {29'd0, bus.framing_err, bus.overrun_err, bus.parity_err}, 32'd0);
        reset = 1'b1;
        idle(5);

        // Clean frame with latency and mid-frame bit_idx probe
        clear_counts();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, -1, 1'b1);
        idle(20);
        check_eq("clean_latency", 32'(valid_rise_cyc - start_cyc), 32'(STOP_EDGE));
        check_eq("clean_valid_rises", 32'(valid_rises), 32'd1);
        check_eq("clean_flags", 32'(fe_cnt + oe_cnt + pe_cnt), 32'd0);
        check_eq("clean_idle_idx", 32'(bus.bit_idx), 32'd0);

        // Back-to-back frames
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pats[i]);
            send_frame(pats[i], 1'b1, ^pats[i], 1'b0, -1, 1'b0);
        end
        idle(20);
        check_eq("b2b_valid_rises", 32'(valid_rises), 32'd4);
        check_eq("b2b_queue", 32'(exp_q.size()), 32'd0);

        // False start: 4-clk glitch
        clear_counts();
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(24);
        check_eq("fstart_busy_seen", 32'(busy_seen), 32'd1);
        check_eq("fstart_busy_end", 32'(bus.busy), 32'd0);
        check_eq("fstart_no_valid", 32'(valid_rises), 32'd0);
        check_eq("fstart_flags", 32'(fe_cnt + oe_cnt + pe_cnt), 32'd0);

        // Framing error, line then held low
        clear_counts();
        send_frame(8'hA5, 1'b0, ^8'hA5, 1'b0, -1, 1'b0);
        busy_seen = 1'b0;
        idle(40);
        check_eq("frame_err_count", 32'(fe_cnt), 32'd1);
        check_eq("frame_no_valid", 32'(valid_rises), 32'd0);
        check_eq("frame_no_restart", 32'(busy_seen), 32'd0);
        rx_in = 1'b1;
        idle(32);

        // Overrun
        clear_counts();
        bus.data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0, -1, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0, -1, 1'b0);
        idle(20);
        check_eq("ovr_data_kept", 32'(bus.data_out), 32'h11);
        check_eq("ovr_valid", 32'(bus.data_valid), 32'd1);
        check_eq("ovr_pulse", 32'(oe_cnt), 32'd1);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, ^8'h33, 1'b1, -1, 1'b0);
        idle(5);
        check_eq("ovr_reload_data", 32'(bus.data_out), 32'h33);
        check_eq("ovr_reload_valid", 32'(bus.data_valid), 32'd1);
        check_eq("ovr_no_new_pulse", 32'(oe_cnt), 32'd1);
        check_eq("ovr_q_after_read", 32'(exp_q.size()), 32'd1);
        bus.data_ready = 1'b1;
        idle(5);
        check_eq("ovr_drained", 32'(exp_q.size()), 32'd0);

        // Mid-frame reset during data bit 4 with a full holding register
        bus.data_ready = 1'b0;
        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, -1, 1'b0);
        idle(10);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, OS * 5 + 8, 1'b0);
        bus.data_ready = 1'b1;
        idle(20);
        clear_counts();
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, -1, 1'b0);
        idle(20);
        check_eq("post_rst_rises", 32'(valid_rises), 32'd1);
        check_eq("post_rst_flags", 32'(fe_cnt + oe_cnt + pe_cnt), 32'd0);

`ifdef UART_RX_PARITY_EN
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        idle(20);
        check_eq("par_bad_pulse", 32'(pe_cnt), 32'd1);
        check_eq("par_bad_no_valid", 32'(valid_rises), 32'd0);
        clear_counts();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        idle(20);
        check_eq("par_good_rises", 32'(valid_rises), 32'd1);
        check_eq("par_good_no_err", 32'(pe_cnt), 32'd0);
`endif

        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
